// File: rtl/io_read_port_ctrl.sv
// io_read_port_ctrl
//   Decodes I/O read requests into registered one-hot port read enables. Each
//   accepted read is tracked down a short return pipeline: the addressed
//   port's data word is captured two edges after acceptance and then appears
//   on data_out, tagged with its port index, PIPE_DEPTH-1 edges later.
//
// Ports
//   clock, reset_n      : clock; asynchronous active-low reset
//   req_valid           : read request this cycle
//   addr_in_io_range    : request address is inside the I/O read window
//   port_addr           : target port index
//   port_ready          : per-port data-available flags
//   port_data           : packed port data, port p at [p*WORD_WIDTH +: WORD_WIDTH]
//   rden                : registered one-hot port read enables
//   io_stall            : registered, request refused because the port was not ready
//   addr_error          : registered, request addressed a non-existent port
//   data_out, data_valid, data_port : returned word, its valid flag and its port tag
module io_read_port_ctrl #(
  parameter int PORT_COUNT      = 4,
  parameter int PORT_ADDR_WIDTH = 2,
  parameter int WORD_WIDTH      = 36,
  parameter int PIPE_DEPTH      = 1,
  parameter int READY_GATE      = 1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             req_valid,
  input  logic                             addr_in_io_range,
  input  logic [PORT_ADDR_WIDTH-1:0]       port_addr,
  input  logic [PORT_COUNT-1:0]            port_ready,
  input  logic [PORT_COUNT*WORD_WIDTH-1:0] port_data,
  output logic [PORT_COUNT-1:0]            rden,
  output logic                             io_stall,
  output logic                             addr_error,
  output logic [WORD_WIDTH-1:0]            data_out,
  output logic                             data_valid,
  output logic [PORT_ADDR_WIDTH-1:0]       data_port
);

  typedef struct packed {
    logic [PORT_ADDR_WIDTH-1:0] tag;
    logic [WORD_WIDTH-1:0]      data;
  } ret_t;

  logic [PORT_COUNT-1:0]      hit;
  logic                       req_io, addr_ok, rdy_ok;
  logic [PORT_COUNT-1:0]      rden_d, rden_q;
  logic                       io_stall_d, io_stall_q;
  logic                       addr_error_d, addr_error_q;
  // vld_pipe[0]: the port is driving data for a read accepted one edge ago.
  // vld_pipe[k], k>=1: return stage k holds a valid word.
  logic [PIPE_DEPTH:0]        vld_pipe_d, vld_pipe_q;
  logic [PORT_ADDR_WIDTH-1:0] tag0_d, tag0_q;
  logic [WORD_WIDTH-1:0]      rd_word;
  ret_t                       ret_d [1:PIPE_DEPTH];
  ret_t                       ret_q [1:PIPE_DEPTH];

  // Request decode. The one-hot hit vector doubles as the range check, so an
  // out-of-range port_addr never indexes port_ready.
  always_comb begin : decode
    hit = '0;
    for (int p = 0; p < PORT_COUNT; p++)
      hit[p] = (port_addr == PORT_ADDR_WIDTH'(p));
    req_io       = req_valid & addr_in_io_range;
    addr_ok      = |hit;
    rdy_ok       = (READY_GATE == 0) || (|(hit & port_ready));
    rden_d       = (req_io && addr_ok && rdy_ok) ? hit : '0;
    io_stall_d   = req_io && addr_ok && !rdy_ok;
    addr_error_d = req_io && !addr_ok;
  end

  // Return path. The tag is recovered from the registered one-hot enable, so
  // it lines up with the cycle in which the port drives its data.
  always_comb begin : ret_path
    tag0_d = tag0_q;
    for (int p = 0; p < PORT_COUNT; p++)
      if (rden_q[p]) tag0_d = PORT_ADDR_WIDTH'(p);

    rd_word = '0;
    for (int p = 0; p < PORT_COUNT; p++)
      if (tag0_q == PORT_ADDR_WIDTH'(p)) rd_word = port_data[p*WORD_WIDTH +: WORD_WIDTH];

    vld_pipe_d = {vld_pipe_q[PIPE_DEPTH-1:0], |rden_q};

    // Stages only load when a valid word arrives, so data_out holds the last
    // returned word between returns.
    if (vld_pipe_q[0]) begin
      ret_d[1].tag  = tag0_q;
      ret_d[1].data = rd_word;
    end else begin
      ret_d[1] = ret_q[1];
    end
    for (int k = 2; k <= PIPE_DEPTH; k++)
      ret_d[k] = vld_pipe_q[k-1] ? ret_q[k-1] : ret_q[k];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rden_q       <= '0;
      io_stall_q   <= 1'b0;
      addr_error_q <= 1'b0;
      vld_pipe_q   <= '0;
      tag0_q       <= '0;
      for (int k = 1; k <= PIPE_DEPTH; k++) ret_q[k] <= '0;
    end else begin
      rden_q       <= rden_d;
      io_stall_q   <= io_stall_d;
      addr_error_q <= addr_error_d;
      vld_pipe_q   <= vld_pipe_d;
      tag0_q       <= tag0_d;
      for (int k = 1; k <= PIPE_DEPTH; k++) ret_q[k] <= ret_d[k];
    end
  end

  assign rden       = rden_q;
  assign io_stall   = io_stall_q;
  assign addr_error = addr_error_q;
  assign data_valid = vld_pipe_q[PIPE_DEPTH];
  assign data_out   = ret_q[PIPE_DEPTH].data;
  assign data_port  = ret_q[PIPE_DEPTH].tag;

endmodule

// File: tb/tb_io_read_port_ctrl.sv
// Scoreboard bench for io_read_port_ctrl: five ports (addresses 5..7 are
// non-existent), three return stages, ready gating on.
module tb_io_read_port_ctrl;

  localparam int PC = 5;
  localparam int AW = 3;
  localparam int WW = 36;
  localparam int PD = 3;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid, addr_in_io_range;
  logic [AW-1:0]     port_addr;
  logic [PC-1:0]     port_ready;
  logic [PC*WW-1:0]  port_data;
  logic [PC-1:0]     rden;
  logic              io_stall, addr_error, data_valid;
  logic [WW-1:0]     data_out;
  logic [AW-1:0]     data_port;

  io_read_port_ctrl #(
    .PORT_COUNT(PC), .PORT_ADDR_WIDTH(AW), .WORD_WIDTH(WW),
    .PIPE_DEPTH(PD), .READY_GATE(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid),
    .addr_in_io_range(addr_in_io_range), .port_addr(port_addr),
    .port_ready(port_ready), .port_data(port_data), .rden(rden),
    .io_stall(io_stall), .addr_error(addr_error), .data_out(data_out),
    .data_valid(data_valid), .data_port(data_port)
  );

  always #5 clock = ~clock;

  // Edge counter: at the falling edge after rising edge n, cyc == n.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int chk; logic [PC-1:0] rden; logic stall; logic err; } ctl_t;
  typedef struct { int chk; logic [AW-1:0] tag; logic [WW-1:0] data; } ret_t;

  ctl_t ctlq[$];
  ret_t retq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [WW-1:0] last_data = '0;

  // Word that port p drives during the cycle sampled at rising edge k.
  function automatic logic [WW-1:0] dfun(input int k, input int p);
    logic [31:0] h;
    h = 32'(k) * 32'h9E3779B1 ^ 32'(p + 1) * 32'h85EBCA6B;
    h = h ^ (h >> 15);
    return {4'(p), h};
  endfunction

  // Drive one cycle of inputs (sampled at the next rising edge k) and record
  // what the reference rules predict for it.
  task automatic drive(input logic rv, input logic inr, input logic [AW-1:0] a,
                       input logic [PC-1:0] rdy);
    int   k;
    logic exists, rsel, acc;
    ctl_t c;
    ret_t r;
    k = cyc + 1;
    req_valid = rv; addr_in_io_range = inr; port_addr = a; port_ready = rdy;
    for (int p = 0; p < PC; p++) port_data[p*WW +: WW] = dfun(k, p);
    exists = int'(a) < PC;
    rsel   = exists ? rdy[a] : 1'b0;
    acc    = rv && inr && exists && rsel;
    c.chk   = k;
    c.rden  = acc ? PC'(1 << a) : '0;
    c.stall = rv && inr && exists && !rsel;
    c.err   = rv && inr && !exists;
    ctlq.push_back(c);
    if (acc) begin
      r.chk = k + 1 + PD; r.tag = a; r.data = dfun(k + 2, int'(a));
      retq.push_back(r);
    end
  endtask

  task automatic step(input logic rv, input logic inr, input logic [AW-1:0] a,
                      input logic [PC-1:0] rdy);
    drive(rv, inr, a, rdy);
    @(negedge clock);
  endtask

  task automatic rand_step();
    step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
         AW'($urandom_range(0, 7)), PC'($urandom | $urandom));
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; addr_in_io_range = 1'b0; port_addr = '0; port_ready = '0;
    for (int p = 0; p < PC; p++) port_data[p*WW +: WW] = dfun(cyc + 1, p);
  endtask

  // Monitor / scoreboard.
  initial begin : monitor
    ctl_t ce;
    ret_t re;
    forever begin
      @(negedge clock or negedge reset_n);
      if (!reset_n) begin
        ctlq.delete(); retq.delete(); last_data = '0;
        #1;
        n_tests++;
        if (rden !== '0 || io_stall !== 1'b0 || addr_error !== 1'b0 ||
            data_valid !== 1'b0 || data_out !== '0 || data_port !== '0) begin
          n_fail++;
          $display("FAIL reset_outputs t=%0t: rden=%b stall=%b err=%b dv=%b data_out=%h port=%0d, required all zero",
                   $time, rden, io_stall, addr_error, data_valid, data_out, data_port);
        end
      end else begin
        while (ctlq.size() > 0 && ctlq[0].chk < cyc) begin
          n_tests++; n_fail++;
          $display("FAIL ctl_lost edge=%0d: expectation for edge %0d never checked", cyc, ctlq[0].chk);
          void'(ctlq.pop_front());
        end
        if (ctlq.size() > 0 && ctlq[0].chk == cyc) begin
          ce = ctlq.pop_front();
          n_tests++;
          if (rden !== ce.rden || io_stall !== ce.stall || addr_error !== ce.err) begin
            n_fail++;
            $display("FAIL ctl edge=%0d: rden=%b stall=%b err=%b, required rden=%b stall=%b err=%b",
                     cyc, rden, io_stall, addr_error, ce.rden, ce.stall, ce.err);
          end
        end
        while (retq.size() > 0 && retq[0].chk < cyc) begin
          n_tests++; n_fail++;
          $display("FAIL ret_lost edge=%0d: return due at edge %0d never seen", cyc, retq[0].chk);
          void'(retq.pop_front());
        end
        if (data_valid === 1'b1) begin
          n_tests++;
          if (retq.size() == 0 || retq[0].chk != cyc) begin
            n_fail++;
            $display("FAIL ret_unexpected edge=%0d: data_valid=1 port=%0d data=%h, required data_valid=0",
                     cyc, data_port, data_out);
          end else begin
            re = retq.pop_front();
            if (data_port !== re.tag || data_out !== re.data) begin
              n_fail++;
              $display("FAIL ret_data edge=%0d: port=%0d data=%h, required port=%0d data=%h",
                       cyc, data_port, data_out, re.tag, re.data);
            end
            last_data = re.data;
          end
        end else begin
          if (retq.size() > 0 && retq[0].chk == cyc) begin
            n_tests++; n_fail++;
            $display("FAIL ret_missing edge=%0d: data_valid=%b, required 1 (port %0d)",
                     cyc, data_valid, retq[0].tag);
            void'(retq.pop_front());
          end
          n_tests++;
          if (data_out !== last_data) begin
            n_fail++;
            $display("FAIL data_hold edge=%0d: data_out=%h, required held %h", cyc, data_out, last_data);
          end
        end
      end
    end
  end

  initial begin : stimulus
    reset_n = 1'b0;
    port_data = '0;
    idle_inputs();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    // First edge after release carries a real request.
    step(1, 1, 3'd2, 5'b11111);
    // Back-to-back reads to every port, then repeated port.
    for (int p = 0; p < PC; p++) step(1, 1, AW'(p), 5'b11111);
    step(1, 1, 3'd4, 5'b11111);
    step(1, 1, 3'd4, 5'b11111);
    // Not-ready stall, missing ports, outside window, no request.
    step(1, 1, 3'd1, 5'b11101);
    step(1, 1, 3'd0, 5'b00000);
    step(1, 1, 3'd5, 5'b11111);
    step(1, 1, 3'd7, 5'b11111);
    step(1, 0, 3'd2, 5'b11111);
    step(0, 1, 3'd2, 5'b11111);
    step(1, 1, 3'd3, 5'b11111);
    for (int i = 0; i < 300; i++) rand_step();

    // Reset one cycle after an accepted read: in-flight return is discarded.
    step(1, 1, 3'd1, 5'b11111);
    drive(0, 0, 3'd0, 5'b00000);
    @(posedge clock);
    #2 reset_n = 1'b0;
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) step(0, 0, 3'd0, 5'b00000);
    for (int i = 0; i < 300; i++) rand_step();
    for (int i = 0; i < PD + 4; i++) step(0, 0, 3'd0, 5'b00000);

    @(posedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_read_port_ctrl.md
IO_READ_PORT_CTRL -- requirements
Module: io_read_port_ctrl

Interface
REQ-001 Parameter PORT_COUNT, default 4: number of I/O read ports, 1..16.
REQ-002 Parameter PORT_ADDR_WIDTH, default 2: width of port_addr, >= clog2(PORT_COUNT).
REQ-003 Parameter WORD_WIDTH, default 36: data width per port.
REQ-004 Parameter PIPE_DEPTH, default 1: registered data-return stages after port sampling, 1..4.
REQ-005 Parameter READY_GATE, default 1: 1 = rden gated by port_ready; 0 = rden ungated, no stalls.
REQ-006 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-007 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 Port req_valid, input, 1: read request this cycle.
REQ-009 Port addr_in_io_range, input, 1: request address falls in the I/O read window.
REQ-010 Port port_addr, input, PORT_ADDR_WIDTH: target port index.
REQ-011 Port port_ready, input, PORT_COUNT: per-port data-available flag.
REQ-012 Port port_data, input, PORT_COUNT*WORD_WIDTH: port p occupies bits [p*WORD_WIDTH +: WORD_WIDTH].
REQ-013 Port rden, output, PORT_COUNT: registered one-hot read enables.
REQ-014 Port io_stall, output, 1: registered; request refused because the port is not ready.
REQ-015 Port addr_error, output, 1: registered; request addressed a non-existent port.
REQ-016 Port data_out, output, WORD_WIDTH: returned read data.
REQ-017 Port data_valid, output, 1: data_out holds valid returned data.
REQ-018 Port data_port, output, PORT_ADDR_WIDTH: port index tag accompanying data_out.

Function
REQ-019 A request is accepted at edge E0 when req_valid=1, addr_in_io_range=1, port_addr<PORT_COUNT and (READY_GATE=0 or port_ready[port_addr]=1).
REQ-020 On acceptance, rden[port_addr] is 1 and all other rden bits are 0 from E0 to E1; rden is never multi-hot.
REQ-021 Any non-accepted cycle drives rden to all-zero at the next edge; rden never stays high for more than one cycle per request.
REQ-022 When req_valid=1, addr_in_io_range=1, port_addr<PORT_COUNT, READY_GATE=1 and port_ready[port_addr]=0, io_stall is 1 for E0..E1 and rden stays all-zero.
REQ-023 When req_valid=1, addr_in_io_range=1 and port_addr>=PORT_COUNT, addr_error is 1 for E0..E1 and rden/io_stall stay 0.
REQ-024 When req_valid=0 or addr_in_io_range=0, rden, io_stall and addr_error are all 0 at the next edge.
REQ-025 The port drives data during E1..E2; the block samples port_data slice [port] at E2 into stage 1, together with a valid bit and a port tag.
REQ-026 Stages 2..PIPE_DEPTH are plain shift registers of {valid, tag, data}; data_out, data_valid and data_port are the last stage.
REQ-027 Accepted request at E0 yields data_valid=1 for exactly one cycle, E(1+PIPE_DEPTH)..E(2+PIPE_DEPTH); load-to-use latency is 1+PIPE_DEPTH cycles.
REQ-028 Back-to-back accepted requests on consecutive cycles, to the same or different ports, return in order with one data_valid per cycle and no loss.
REQ-029 Stalled or errored requests insert no valid bit into the return pipeline.
REQ-030 data_out when data_valid=0 holds the last shifted value; it is not zeroed.
REQ-031 port_ready changing in the same cycle as a request is evaluated by its value sampled at E0 only.

Reset
REQ-032 reset_n=0 asynchronously forces rden=0, io_stall=0, addr_error=0, all pipeline valid bits=0, data_port=0 and data_out=0.
REQ-033 Reset asserted mid-operation discards all in-flight returns; after reset_n rises, no data_valid appears until a new accepted request completes.
REQ-034 The first request sampled at the first rising edge after reset_n deassertion is processed normally.

Verification
REQ-035 PORT_COUNT=4, PIPE_DEPTH=1, port_ready=4'b1111, request port 2 at E0 with port_data slice 2 = 36'h0_1234_5678 during E1..E2 -> rden=4'b0100 for E0..E1; data_out=36'h012345678, data_port=2, data_valid=1 for E2..E3.
REQ-036 READY_GATE=1, port_ready[1]=0, request port 1 -> io_stall=1 for one cycle, rden=0, no data_valid; with READY_GATE=0, same stimulus -> rden=4'b0010, no stall.
REQ-037 PORT_COUNT=3, PORT_ADDR_WIDTH=2, request port 3 -> addr_error=1 for one cycle, rden=0, no data_valid.
REQ-038 PIPE_DEPTH=3, requests to ports 0,1,2,3 on four consecutive cycles -> four consecutive data_valid cycles starting 4 cycles after the first request, tags 0,1,2,3 in order.
REQ-039 Assert reset_n=0 one cycle after an accepted request with PIPE_DEPTH=2 -> rden and all outputs 0 immediately, and no data_valid after release.
